fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Each cycle it captures the fetched PC and its instruction word into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. When the queue fills, it back-pressures fetch. A flush, driven by a taken branch or an exception redirect, discards all queued entries. It also tags misaligned PCs so decode can raise a fetch fault.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue_mem.sv | 32 +++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
// Optional same-cycle bypass in fetch_queue is enabled by defining FETCHQ_BYPASS_EN.
package fetch_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_AW    = 64;
    localparam int FQ_IW    = 32;

    typedef struct packed {
        logic [FQ_AW-1:0] pc;
        logic [FQ_IW-1:0] instr;
        logic             fault;
    } fq_entry_t;

    // A fetch PC must be word aligned; anything else becomes a fetch fault in decode.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return |pc_lsb;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one write port, one asynchronous read port,
// whole array cleared by the asynchronous active-low reset.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  fq_entry_t     i_wdata,
    input  logic [PW-1:0] i_raddr,
    output fq_entry_t     o_rdata
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush and misalignment tagging.
// Define FETCHQ_BYPASS_EN to let a push into an empty queue reach decode in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int IW    = FQ_IW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_F,
    input  logic [AW-1:0]            imem_addr_F,
    input  logic [IW-1:0]            imem_data_F,
    output logic                     stall_F,
    input  logic                     flush_D,
    output logic                     valid_D,
    input  logic                     ready_D,
    output logic [IW-1:0]            instr_D,
    output logic [AW-1:0]            pc_D,
    output logic                     fault_D,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;

    fq_entry_t w_wr_entry;
    fq_entry_t w_rd_entry;
    fq_entry_t w_out_entry;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_byp;
    logic      w_write;
    logic      w_read;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Only count and ready_D feed stall_F, so fetch never sees a loop through push_F.
    assign stall_F = w_full & ~ready_D;
    assign w_push  = push_F & ~stall_F & ~flush_D;

`ifdef FETCHQ_BYPASS_EN
    assign w_byp = w_empty & push_F & ~flush_D;
`else
    assign w_byp = 1'b0;
`endif

    assign valid_D = ~w_empty | w_byp;
    assign w_pop   = valid_D & ready_D & ~flush_D;

    // A bypassed word taken by decode is never stored, and nothing leaves storage for it.
    assign w_write = w_push & ~(w_byp & ready_D);
    assign w_read  = w_pop & ~w_byp;

    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.pc    = FQ_AW'(imem_addr_F);
        w_wr_entry.instr = FQ_IW'(imem_data_F);
        w_wr_entry.fault = pc_misaligned(imem_addr_F[1:0]);
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_write),
        .i_waddr (r_wp),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rp),
        .o_rdata (w_rd_entry)
    );

    assign w_out_entry = w_byp ? w_wr_entry : w_rd_entry;
    assign pc_D        = AW'(w_out_entry.pc);
    assign instr_D     = IW'(w_out_entry.instr);
    assign fault_D     = w_out_entry.fault;
    assign count       = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush_D) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_write) r_wp <= r_wp + PW'(1);
            if (w_read)  r_rp <= r_rp + PW'(1);
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences for reset/wrap/bypass,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int IW    = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   push_F;
    logic [AW-1:0]          imem_addr_F;
    logic [IW-1:0]          imem_data_F;
    logic                   stall_F;
    logic                   flush_D;
    logic                   valid_D;
    logic                   ready_D;
    logic [IW-1:0]          instr_D;
    logic [AW-1:0]          pc_D;
    logic                   fault_D;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_F      (push_F),
        .imem_addr_F (imem_addr_F),
        .imem_data_F (imem_data_F),
        .stall_F     (stall_F),
        .flush_D     (flush_D),
        .valid_D     (valid_D),
        .ready_D     (ready_D),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .fault_D     (fault_D),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] iw(input logic [63:0] pc);
        return 32'h5A00_0013 ^ pc[31:0];
    endfunction

    typedef struct {
        logic        push;
        logic [63:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        flush;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] einstr;
        logic        efault;
        int          ecnt;
        logic        estall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic push, input logic [63:0] addr, input logic [31:0] data,
                       input logic ready, input logic flush, input logic ev,
                       input logic [63:0] epc, input logic [31:0] einstr, input logic efault,
                       input int ecnt, input logic estall);
        vec_t v;
        v.push = push; v.addr = addr; v.data = data; v.ready = ready; v.flush = flush;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.efault = efault;
        v.ecnt = ecnt; v.estall = estall;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        push_F = 1'b0; imem_addr_F = '0; imem_data_F = '0;
        ready_D = 1'b0; flush_D = 1'b0;
    endtask

    fq_entry_t model_q[$];

    initial begin
        logic [63:0] seen[$];
        int          next_pc;

        reset = 1'b0;
        idle_inputs();
        #2;
        chk("reset.valid", 64'(valid_D), 64'd0);
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.stall", 64'(stall_F), 64'd0);
        chk("reset.pc", pc_D, 64'd0);
        chk("reset.instr", 64'(instr_D), 64'd0);
        chk("reset.fault", 64'(fault_D), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

`ifndef FETCHQ_BYPASS_EN
        // fill, full push rejected, full push+pop, drain
        add(1, 64'h0,  iw(64'h0),  0, 0, 0, 64'h0,  32'h0,      0, 0, 0);
        add(1, 64'h4,  iw(64'h4),  0, 0, 1, 64'h0,  iw(64'h0),  0, 1, 0);
        add(1, 64'h8,  iw(64'h8),  0, 0, 1, 64'h0,  iw(64'h0),  0, 2, 0);
        add(1, 64'hC,  iw(64'hC),  0, 0, 1, 64'h0,  iw(64'h0),  0, 3, 0);
        add(1, 64'h10, iw(64'h10), 0, 0, 1, 64'h0,  iw(64'h0),  0, 4, 1);
        add(1, 64'h10, iw(64'h10), 1, 0, 1, 64'h0,  iw(64'h0),  0, 4, 0);
        add(0, 64'h0,  32'h0,      1, 0, 1, 64'h4,  iw(64'h4),  0, 4, 0);
        add(0, 64'h0,  32'h0,      1, 0, 1, 64'h8,  iw(64'h8),  0, 3, 0);
        add(0, 64'h0,  32'h0,      1, 0, 1, 64'hC,  iw(64'hC),  0, 2, 0);
        add(0, 64'h0,  32'h0,      1, 0, 1, 64'h10, iw(64'h10), 0, 1, 0);
        add(0, 64'h0,  32'h0,      0, 0, 0, 64'h0,  32'h0,      0, 0, 0);
        // flush with three queued and a push in the same cycle
        add(1, 64'h20,  iw(64'h20),  0, 0, 0, 64'h0,   32'h0,       0, 0, 0);
        add(1, 64'h24,  iw(64'h24),  0, 0, 1, 64'h20,  iw(64'h20),  0, 1, 0);
        add(1, 64'h28,  iw(64'h28),  0, 0, 1, 64'h20,  iw(64'h20),  0, 2, 0);
        add(1, 64'h100, iw(64'h100), 0, 1, 1, 64'h20,  iw(64'h20),  0, 3, 0);
        add(0, 64'h0,   32'h0,       0, 0, 0, 64'h0,   32'h0,       0, 0, 0);
        add(1, 64'h200, iw(64'h200), 0, 0, 0, 64'h0,   32'h0,       0, 0, 0);
        add(0, 64'h0,   32'h0,       1, 0, 1, 64'h200, iw(64'h200), 0, 1, 0);
        add(0, 64'h0,   32'h0,       0, 0, 0, 64'h0,   32'h0,       0, 0, 0);
        // misaligned PC tagging
        add(1, 64'h6, 32'hD503201F, 0, 0, 0, 64'h0, 32'h0,       0, 0, 0);
        add(1, 64'h8, iw(64'h8),    1, 0, 1, 64'h6, 32'hD503201F, 1, 1, 0);
        add(0, 64'h0, 32'h0,        1, 0, 1, 64'h8, iw(64'h8),    0, 1, 0);
        add(0, 64'h0, 32'h0,        0, 0, 0, 64'h0, 32'h0,        0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            push_F = tbl[i].push; imem_addr_F = tbl[i].addr; imem_data_F = tbl[i].data;
            ready_D = tbl[i].ready; flush_D = tbl[i].flush;
            @(negedge clk);
            chk($sformatf("tbl[%0d].valid", i), 64'(valid_D), 64'(tbl[i].ev));
            chk($sformatf("tbl[%0d].count", i), 64'(count), 64'(tbl[i].ecnt));
            chk($sformatf("tbl[%0d].stall", i), 64'(stall_F), 64'(tbl[i].estall));
            if (tbl[i].ev) begin
                chk($sformatf("tbl[%0d].pc", i), pc_D, tbl[i].epc);
                chk($sformatf("tbl[%0d].instr", i), 64'(instr_D), 64'(tbl[i].einstr));
                chk($sformatf("tbl[%0d].fault", i), 64'(fault_D), 64'(tbl[i].efault));
            end
            @(posedge clk); #1;
        end
`else
        // same-cycle bypass into an empty queue, taken by decode
        push_F = 1'b1; imem_addr_F = 64'h500; imem_data_F = iw(64'h500); ready_D = 1'b1;
        #1;
        chk("byp.valid", 64'(valid_D), 64'd1);
        chk("byp.pc", pc_D, 64'h500);
        chk("byp.instr", 64'(instr_D), 64'(iw(64'h500)));
        chk("byp.count_now", 64'(count), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("byp.count_after", 64'(count), 64'd0);
        chk("byp.valid_after", 64'(valid_D), 64'd0);
        @(posedge clk); #1;
`endif
        idle_inputs();

        // ten sequential PCs with ready toggling; pointers wrap past DEPTH
        next_pc = 0;
        for (int cyc = 0; cyc < 60 && (seen.size() < 10 || next_pc < 10); cyc++) begin
            ready_D = (cyc % 2 == 0);
            push_F = (next_pc < 10);
            imem_addr_F = 64'h1000 + 64'(4 * next_pc);
            imem_data_F = iw(imem_addr_F);
            @(negedge clk);
            if (valid_D && ready_D) seen.push_back(pc_D);
            if (push_F && !stall_F) next_pc++;
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("wrap.seen", 64'(seen.size()), 64'd10);
        for (int k = 0; k < 10 && k < seen.size(); k++)
            chk($sformatf("wrap.order[%0d]", k), seen[k], 64'h1000 + 64'(4 * k));
        chk("wrap.empty", 64'(count), 64'd0);

        // asynchronous reset between edges with two entries queued
        push_F = 1'b1; imem_addr_F = 64'h300; imem_data_F = iw(64'h300);
        @(posedge clk); #1;
        imem_addr_F = 64'h304; imem_data_F = iw(64'h304);
        @(posedge clk); #1;
        idle_inputs();
        #2 reset = 1'b0;
        #1;
        chk("rstmid.valid", 64'(valid_D), 64'd0);
        chk("rstmid.count", 64'(count), 64'd0);
        chk("rstmid.pc", pc_D, 64'd0);
        chk("rstmid.instr", 64'(instr_D), 64'd0);
        chk("rstmid.fault", 64'(fault_D), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        push_F = 1'b1; imem_addr_F = 64'h40; imem_data_F = iw(64'h40);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("rstmid.post_count", 64'(count), 64'd1);
        chk("rstmid.post_valid", 64'(valid_D), 64'd1);
        chk("rstmid.post_pc", pc_D, 64'h40);
        ready_D = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("rstmid.drained", 64'(valid_D), 64'd0);
        @(posedge clk); #1;

        // randomized traffic against the queue model
        model_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            int        sz;
            logic      e_valid, e_stall, consumed;
            fq_entry_t head, incoming;
            push_F      = ($urandom_range(0, 99) < 70);
            ready_D     = ($urandom_range(0, 99) < 45);
            flush_D     = ($urandom_range(0, 31) == 0);
            imem_addr_F = {$urandom, $urandom};
            imem_data_F = $urandom;
            incoming.pc = imem_addr_F;
            incoming.instr = imem_data_F;
            incoming.fault = (imem_addr_F % 4) != 0;
            sz = model_q.size();
            e_stall = (sz == DEPTH) && !ready_D;
`ifdef FETCHQ_BYPASS_EN
            e_valid = (sz > 0) || (push_F && !flush_D);
`else
            e_valid = (sz > 0);
`endif
            head = (sz > 0) ? model_q[0] : incoming;
            @(negedge clk);
            chk("rnd.valid", 64'(valid_D), 64'(e_valid));
            chk("rnd.count", 64'(count), 64'(sz));
            chk("rnd.stall", 64'(stall_F), 64'(e_stall));
            if (e_valid) begin
                chk("rnd.pc", pc_D, head.pc);
                chk("rnd.instr", 64'(instr_D), 64'(head.instr));
                chk("rnd.fault", 64'(fault_D), 64'(head.fault));
            end
            if (flush_D) begin
                model_q.delete();
            end else begin
                consumed = 1'b0;
                if (e_valid && ready_D) begin
                    if (sz > 0) void'(model_q.pop_front());
                    else consumed = 1'b1;
                end
                if (push_F && !e_stall && !consumed) model_q.push_back(incoming);
            end
            @(posedge clk); #1;
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
